bridge_to_mem_words: RTL

- Parametrised bridge-to-memory width adapter; next generation of the byte-serial bridge loader.
- Splits one 32-bit bridge write into 32/MEM_WIDTH sequential memory beats, and assembles the same number of read beats into one 32-bit word.
- Adds three things the byte loader lacks: memory back-pressure (mem_ready), configurable read latency, selectable beat order.
- Also adds busy/done/overrun status to the bridge side.

---
 rtl/bridge_mem_pkg.sv | 26 ++
 rtl/bridge_mem_if.sv | 41 ++++
 rtl/mem_rd_latency_pipe.sv | 32 +++
 rtl/bridge_to_mem_words.sv | 135 +++++++++++++
 4 files changed

// File: rtl/bridge_mem_pkg.sv
// Shared types and elaboration helpers for the bridge-to-memory width adapters.
package bridge_mem_pkg;

  localparam int BUS_W   = 32;
  localparam int MIN_LAT = 1;
  localparam int MAX_LAT = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } state_t;

  function automatic int beats(input int width);
    return BUS_W / width;
  endfunction

  function automatic bit width_legal(input int width);
    return (width == 8) || (width == 16) || (width == 32);
  endfunction

  function automatic bit latency_legal(input int lat);
    return (lat >= MIN_LAT) && (lat <= MAX_LAT);
  endfunction

endpackage

// File: rtl/bridge_mem_if.sv
// Bridge-side request bus and memory-side beat bus; master drives requests.
interface bridge_if;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        bridge_wr;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        selected;
  logic        busy;
  logic        rd_done;
  logic        overrun;

  modport master (
    output bridge_addr, bridge_wr_data, bridge_wr, bridge_rd,
    input  bridge_rd_data, selected, busy, rd_done, overrun
  );
  modport slave (
    input  bridge_addr, bridge_wr_data, bridge_wr, bridge_rd,
    output bridge_rd_data, selected, busy, rd_done, overrun
  );
endinterface

interface mem_if #(
  parameter int MEM_WIDTH = 8
);
  logic [31:0]          mem_address;
  logic [MEM_WIDTH-1:0] mem_wr_data;
  logic                 mem_wr;
  logic                 mem_rd;
  logic                 mem_ready;
  logic [MEM_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_address, mem_wr_data, mem_wr, mem_rd,
    input  mem_ready, mem_rd_data
  );
  modport slave (
    input  mem_address, mem_wr_data, mem_wr, mem_rd,
    output mem_ready, mem_rd_data
  );
endinterface

// File: rtl/mem_rd_latency_pipe.sv
// Fixed-latency read-return tracker: valid shift register plus returned-beat counter.
module mem_rd_latency_pipe #(
  parameter int LATENCY = 2,
  parameter int BEATS   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic accept,
  output logic capture,
  output logic last
);

  logic [LATENCY-1:0] vld_p;
  logic [3:0]         ret_cnt;

  // The oldest stage marks the cycle whose memory data belongs to an accepted beat.
  assign capture = vld_p[LATENCY-1];
  assign last    = capture && (ret_cnt == 4'(BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p   <= '0;
      ret_cnt <= '0;
    end else begin
      vld_p <= (vld_p << 1) | LATENCY'(accept);
      if (capture) begin
        ret_cnt <= last ? 4'd0 : ret_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bridge_to_mem_words.sv
// Splits 32-bit bridge writes into MEM_WIDTH beats and assembles read beats into words.
module bridge_to_mem_words
  import bridge_mem_pkg::*;
#(
  parameter logic [31:0] valid_bits   = 32'hFFFF_FFFF,
  parameter int          MEM_WIDTH    = 8,
  parameter int          READ_LATENCY = 2,
  parameter bit          BIG_ENDIAN   = 1'b1
) (
  input logic     clk,
  input logic     reset,
  bridge_if.slave bus,
  mem_if.master   mem
);

  localparam int          BEATS     = beats(MEM_WIDTH);
  localparam logic [31:0] STEP      = 32'(MEM_WIDTH / 8);
  localparam logic [2:0]  LAST_BEAT = 3'(BEATS - 1);

  if (!width_legal(MEM_WIDTH)) begin : g_bad_width
    $error("MEM_WIDTH must be 8, 16 or 32");
  end
  if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..8");
  end

  state_t      state;
  logic [31:0] beat_addr;
  logic [31:0] wr_word;
  logic [31:0] asm_word;
  logic [31:0] asm_next;
  logic [31:0] rd_word;
  logic [2:0]  beat_cnt;
  logic        is_read;
  logic        wr_req;
  logic        rd_req;
  logic        done_pulse;
  logic        overrun_flag;
  logic        strobe;
  logic        accept;
  logic        rd_capture;
  logic        rd_last;

  assign bus.selected = ((bus.bridge_addr & ~valid_bits) == 32'd0);
  assign strobe       = (bus.bridge_wr | bus.bridge_rd) & bus.selected;
  assign accept       = (wr_req | rd_req) & mem.mem_ready;

  mem_rd_latency_pipe #(
    .LATENCY (READ_LATENCY),
    .BEATS   (BEATS)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .accept  (rd_req & mem.mem_ready),
    .capture (rd_capture),
    .last    (rd_last)
  );

  // Shifting by the full bus width empties the register, so MEM_WIDTH=32 needs no special case.
  always_comb begin
    asm_next = asm_word;
    if (BIG_ENDIAN) begin
      asm_next = (asm_word << MEM_WIDTH) | 32'(mem.mem_rd_data);
    end else begin
      asm_next = (asm_word >> MEM_WIDTH) | (32'(mem.mem_rd_data) << (BUS_W - MEM_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_addr    <= '0;
      wr_word      <= '0;
      asm_word     <= '0;
      rd_word      <= '0;
      beat_cnt     <= '0;
      is_read      <= 1'b0;
      wr_req       <= 1'b0;
      rd_req       <= 1'b0;
      done_pulse   <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (strobe && (state != IDLE)) begin
        overrun_flag <= 1'b1;
      end
      if (rd_capture) begin
        asm_word <= asm_next;
      end
      case (state)
        IDLE: begin
          if (strobe) begin
            beat_addr <= bus.bridge_addr;
            wr_word   <= bus.bridge_wr_data;
            is_read   <= ~bus.bridge_wr;
            wr_req    <= bus.bridge_wr;
            rd_req    <= ~bus.bridge_wr;
            beat_cnt  <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            beat_addr <= beat_addr + STEP;
            wr_word   <= BIG_ENDIAN ? (wr_word << MEM_WIDTH) : (wr_word >> MEM_WIDTH);
            beat_cnt  <= beat_cnt + 3'd1;
            if (beat_cnt == LAST_BEAT) begin
              wr_req <= 1'b0;
              rd_req <= 1'b0;
              state  <= is_read ? DRAIN : IDLE;
            end
          end
        end
        DRAIN: begin
          if (rd_last) begin
            rd_word    <= asm_next;
            done_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bridge_rd_data = rd_word;
  assign bus.busy           = (state != IDLE);
  assign bus.rd_done        = done_pulse;
  assign bus.overrun        = overrun_flag;
  assign mem.mem_address    = beat_addr;
  assign mem.mem_wr_data    = BIG_ENDIAN ? wr_word[31 -: MEM_WIDTH] : wr_word[MEM_WIDTH-1:0];
  assign mem.mem_wr         = wr_req;
  assign mem.mem_rd         = rd_req;

endmodule
